winograd_ewmm_accum: RTL

- Element-wise multiply-accumulate stage directly downstream of the weight memory controller.
- Joins one 6x6 transformed weight tile with one 6x6 transformed data tile of the same input channel (id) and forms the 36 products.
- Accumulates the products across input channels 0..total_id-1 for one output channel (od).
- Emits the accumulated 6x6 tile, tagged with its od, to the inverse-transform stage.

---
 rtl/winocnn_pkg.sv | 19 +
 rtl/ewmm_tile_mult.sv | 73 +++++++
 rtl/winograd_ewmm_accum.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/winocnn_pkg.sv
// Shared constants, tile types and FSM encoding for the Winograd CNN datapath.
// Tiles are packed [row][col][bits]; element (i,j) sits at flat bit offset (i*TILE+j)*W.
package winocnn_pkg;

    localparam int unsigned TILE   = 6;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned WGT_W  = 12;
    localparam int unsigned PROD_W = DATA_W + WGT_W;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned NUM_EL = TILE * TILE;

    typedef logic signed [TILE-1:0][TILE-1:0][DATA_W-1:0] data_tile_t;
    typedef logic signed [TILE-1:0][TILE-1:0][WGT_W-1:0]  wgt_tile_t;
    typedef logic signed [TILE-1:0][TILE-1:0][PROD_W-1:0] prod_tile_t;
    typedef logic signed [TILE-1:0][TILE-1:0][ACC_W-1:0]  acc_tile_t;

    typedef enum logic [0:0] {IDLE, ACCUM} state_e;

endpackage

// File: rtl/ewmm_tile_mult.sv
// Stage M: registered 36-lane signed element-wise multiply of a weight tile and a
// data tile, with the beat's valid/od/first/last tags carried alongside.
// Ports:
//   clk, reset        clock, async active-low reset
//   valid_i, od_i,
//   first_i, last_i   beat tags entering the stage
//   wgt_tile_i        flat weight tile (NUM_EL x WGT_W)
//   data_tile_i       flat data tile (NUM_EL x DATA_W)
//   valid_o, od_o,
//   first_o, last_o   registered tags
//   prod_tile_o       registered flat product tile (NUM_EL x PROD_W)
module ewmm_tile_mult
    import winocnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [7:0]               od_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic [NUM_EL*WGT_W-1:0]  wgt_tile_i,
    input  logic [NUM_EL*DATA_W-1:0] data_tile_i,
    output logic                     valid_o,
    output logic [7:0]               od_o,
    output logic                     first_o,
    output logic                     last_o,
    output logic [NUM_EL*PROD_W-1:0] prod_tile_o
);

    wgt_tile_t  wgt;
    data_tile_t dat;
    prod_tile_t prod_d, prod_q;
    logic       valid_q, first_q, last_q;
    logic [7:0] od_q;

    assign wgt = wgt_tile_i;
    assign dat = data_tile_i;

    always_comb begin
        prod_d = '0;
        for (int i = 0; i < TILE; i++) begin
            for (int j = 0; j < TILE; j++) begin
                prod_d[i][j] = $signed(wgt[i][j]) * $signed(dat[i][j]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            od_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            valid_q <= valid_i;
            // Hold products between beats to avoid needless toggling.
            if (valid_i) begin
                od_q    <= od_i;
                first_q <= first_i;
                last_q  <= last_i;
                prod_q  <= prod_d;
            end
        end
    end

    assign valid_o     = valid_q;
    assign od_o        = od_q;
    assign first_o     = first_q;
    assign last_o      = last_q;
    assign prod_tile_o = prod_q;

endmodule

// File: rtl/winograd_ewmm_accum.sv
// Element-wise multiply-accumulate: joins a transformed weight tile and data tile of
// the same input channel, multiplies element-wise, accumulates across input channels
// 0..total_id-1 of one output channel and emits the 6x6 sum tagged with its od.
// Ports:
//   clk, reset                      clock, async active-low reset
//   total_id_i                      input channels per od (0 means 1), static unless idle
//   weight_tile_i/valid/od/id       weight slot input, weight_ready_o handshake
//   data_tile_i/valid/id            data slot input, data_ready_o handshake
//   result_tile_o/valid_o/od_o      accumulated tile, one-cycle valid pulse
//   error_o                         sticky sequencing error
module winograd_ewmm_accum
    import winocnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               total_id_i,
    input  logic [NUM_EL*WGT_W-1:0]  weight_tile_i,
    input  logic                     weight_valid_i,
    input  logic [7:0]               weight_od_i,
    input  logic [3:0]               weight_id_i,
    output logic                     weight_ready_o,
    input  logic [NUM_EL*DATA_W-1:0] data_tile_i,
    input  logic                     data_valid_i,
    input  logic [3:0]               data_id_i,
    output logic                     data_ready_o,
    output logic [NUM_EL*ACC_W-1:0]  result_tile_o,
    output logic                     result_valid_o,
    output logic [7:0]               result_od_o,
    output logic                     error_o
);

    // Operand holding slots.
    logic                     w_full_q, d_full_q;
    logic [NUM_EL*WGT_W-1:0]  w_tile_q;
    logic [NUM_EL*DATA_W-1:0] d_tile_q;
    logic [7:0]               w_od_q;
    logic [3:0]               w_id_q, d_id_q;

    logic fire, w_acc, d_acc;

    assign fire           = w_full_q & d_full_q;
    assign weight_ready_o = ~w_full_q | fire;
    assign data_ready_o   = ~d_full_q | fire;
    assign w_acc          = weight_valid_i & weight_ready_o;
    assign d_acc          = data_valid_i & data_ready_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_full_q <= 1'b0;
            d_full_q <= 1'b0;
            w_tile_q <= '0;
            d_tile_q <= '0;
            w_od_q   <= '0;
            w_id_q   <= '0;
            d_id_q   <= '0;
        end else begin
            if (w_acc) begin
                w_full_q <= 1'b1;
                w_tile_q <= weight_tile_i;
                w_od_q   <= weight_od_i;
                w_id_q   <= weight_id_i;
            end else if (fire) begin
                w_full_q <= 1'b0;
            end
            if (d_acc) begin
                d_full_q <= 1'b1;
                d_tile_q <= data_tile_i;
                d_id_q   <= data_id_i;
            end else if (fire) begin
                d_full_q <= 1'b0;
            end
        end
    end

    // Sequencing FSM.
    state_e     state_q, state_d;
    logic [3:0] exp_id_q, exp_id_d;
    logic [7:0] acc_od_q, acc_od_d;
    logic       err_q, err_d;
    logic [3:0] last_id;
    logic       beat_ok, beat_first, beat_last, issue;

    assign last_id    = (total_id_i == 4'd0) ? 4'd0 : total_id_i - 4'd1;
    assign beat_first = (state_q == IDLE);
    assign beat_last  = (w_id_q == last_id);
    assign beat_ok    = (w_id_q == d_id_q) && (w_id_q == exp_id_q) &&
                        ((state_q == IDLE) || (w_od_q == acc_od_q));

    always_comb begin
        state_d  = state_q;
        exp_id_d = exp_id_q;
        acc_od_d = acc_od_q;
        err_d    = err_q;
        issue    = 1'b0;
        if (fire) begin
            if (!beat_ok) begin
                // Beat is dropped; slots still drain on this fire.
                err_d = 1'b1;
            end else begin
                issue = 1'b1;
                if (state_q == IDLE) begin
                    acc_od_d = w_od_q;
                end
                if (beat_last) begin
                    state_d  = IDLE;
                    exp_id_d = 4'd0;
                end else begin
                    state_d  = ACCUM;
                    exp_id_d = exp_id_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            exp_id_q <= '0;
            acc_od_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_id_q <= exp_id_d;
            acc_od_q <= acc_od_d;
            err_q    <= err_d;
        end
    end

    // Stage M.
    logic                     m_valid, m_first, m_last;
    logic [7:0]               m_od;
    logic [NUM_EL*PROD_W-1:0] m_prod_flat;
    prod_tile_t               m_prod;

    ewmm_tile_mult u_mult (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (issue),
        .od_i        (w_od_q),
        .first_i     (beat_first),
        .last_i      (beat_last),
        .wgt_tile_i  (w_tile_q),
        .data_tile_i (d_tile_q),
        .valid_o     (m_valid),
        .od_o        (m_od),
        .first_o     (m_first),
        .last_o      (m_last),
        .prod_tile_o (m_prod_flat)
    );

    assign m_prod = m_prod_flat;

    // Stage A: wrapping accumulate.
    acc_tile_t  acc_q, acc_d, res_tile_q;
    logic       res_valid_q;
    logic [7:0] res_od_q;

    always_comb begin
        acc_d = acc_q;
        if (m_valid) begin
            for (int i = 0; i < TILE; i++) begin
                for (int j = 0; j < TILE; j++) begin
                    if (m_first) begin
                        acc_d[i][j] = {{(ACC_W-PROD_W){m_prod[i][j][PROD_W-1]}}, m_prod[i][j]};
                    end else begin
                        acc_d[i][j] = acc_q[i][j] +
                                      {{(ACC_W-PROD_W){m_prod[i][j][PROD_W-1]}}, m_prod[i][j]};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            res_tile_q  <= '0;
            res_valid_q <= 1'b0;
            res_od_q    <= '0;
        end else begin
            acc_q       <= acc_d;
            res_valid_q <= m_valid & m_last;
            if (m_valid && m_last) begin
                res_tile_q <= acc_d;
                res_od_q   <= m_od;
            end
        end
    end

    assign result_tile_o  = res_tile_q;
    assign result_valid_o = res_valid_q;
    assign result_od_o    = res_od_q;
    assign error_o        = err_q;

endmodule
